// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM audio paths (playback and microphone input).
package pdm_pkg;

    localparam int PCM_W = 16;
    localparam logic [PCM_W-1:0] MIDSCALE = 16'h8000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pdm_state_e;

    // System clocks per PDM bit; the product is formed in 64 bits to avoid overflow.
    function automatic int calc_clk_count(input int clk_freq_mhz, input int sample_rate);
        longint hz;
        hz = longint'(clk_freq_mhz) * longint'(1000000);
        return int'(hz / longint'(sample_rate));
    endfunction

endpackage

// File: rtl/pdm_fifo.sv
// Synchronous PCM sample FIFO with a registered "not full" ready flag.
module pdm_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_valid,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            pop_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         ready
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic              do_push, do_pop;

    // ready_q always mirrors !full of count_q, so an accepted push always has room.
    assign do_push = push_valid && ready_q;
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign ready    = ready_q;

endmodule

// File: rtl/pdm_output.sv
// PCM-to-PDM transmitter: FIFO-buffered samples drive a first-order sigma-delta modulator.
module pdm_output
    import pdm_pkg::*;
#(
    parameter int CLK_FREQ       = 125,
    parameter int SAMPLE_RATE    = 2400000,
    parameter int OSR            = 64,
    parameter int FIFO_DEPTH     = 4,
    parameter int UNDERRUN_LIMIT = 4
) (
    input  logic                    CLK_IN,
    input  logic                    RST_IN,
    input  logic signed [PCM_W-1:0] PCM_DATA,
    input  logic                    PCM_VALID,
    output logic                    PCM_READY,
    output logic                    AUD_PWM,
    output logic                    AUD_SD,
    output logic                    UNDERRUN,
    output logic                    ACTIVE
);

    localparam int CLK_COUNT = calc_clk_count(CLK_FREQ, SAMPLE_RATE);
    localparam int CNT_W     = (CLK_COUNT > 1) ? $clog2(CLK_COUNT) : 1;
    localparam int IDX_W     = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int UR_W      = $clog2(UNDERRUN_LIMIT + 1);
    localparam int FCNT_W    = $clog2(FIFO_DEPTH + 1);

    function automatic logic [PCM_W-1:0] to_offset(input logic [PCM_W-1:0] pcm);
        return pcm ^ MIDSCALE;
    endfunction

    pdm_state_e         state_q, state_d;
    logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [PCM_W-1:0]   acc_q, acc_d;
    logic [PCM_W-1:0]   cur_u_q, cur_u_d;
    logic [UR_W-1:0]    ur_cnt_q, ur_cnt_d;
    logic               pwm_q, pwm_d;
    logic               underrun_q, underrun_d;
    logic               first_q, first_d;

    logic               bit_en, boundary;
    logic [PCM_W-1:0]   u_now;
    logic [PCM_W:0]     sum;

    logic               fifo_pop, fifo_empty, fifo_ready;
    logic [PCM_W-1:0]   fifo_data;
    logic [FCNT_W-1:0]  fifo_count;

    pdm_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (PCM_W)
    ) u_fifo (
        .clk        (CLK_IN),
        .rst        (RST_IN),
        .push_valid (PCM_VALID),
        .push_data  (PCM_DATA),
        .pop        (fifo_pop),
        .pop_data   (fifo_data),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .ready      (fifo_ready)
    );

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        acc_d      = acc_q;
        pwm_d      = pwm_q;
        cur_u_d    = cur_u_q;
        ur_cnt_d   = ur_cnt_q;
        first_d    = first_q;
        underrun_d = 1'b0;
        fifo_pop   = 1'b0;
        bit_en     = 1'b0;
        boundary   = 1'b0;
        u_now      = cur_u_q;
        sum        = '0;

        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                acc_d     = '0;
                pwm_d     = 1'b0;
                ur_cnt_d  = '0;
                first_d   = 1'b1;
                if (fifo_count >= FCNT_W'(FIFO_DEPTH / 2)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                bit_en    = (clk_cnt_q == CNT_W'(CLK_COUNT - 1));
                clk_cnt_d = bit_en ? '0 : clk_cnt_q + CNT_W'(1);
                if (bit_en) begin
                    // The first bit of a sample is modulated with the freshly loaded value.
                    boundary  = first_q || (bit_idx_q == IDX_W'(OSR - 1));
                    bit_idx_d = boundary ? '0 : bit_idx_q + IDX_W'(1);
                    if (boundary) begin
                        first_d = 1'b0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            u_now    = to_offset(fifo_data);
                            ur_cnt_d = '0;
                        end else begin
                            u_now      = MIDSCALE;
                            underrun_d = 1'b1;
                            ur_cnt_d   = ur_cnt_q + UR_W'(1);
                        end
                        cur_u_d = u_now;
                    end
                    sum   = {1'b0, acc_q} + {1'b0, u_now};
                    acc_d = sum[PCM_W-1:0];
                    pwm_d = sum[PCM_W];
                    if (underrun_d && (ur_cnt_d == UR_W'(UNDERRUN_LIMIT))) begin
                        state_d   = ST_IDLE;
                        clk_cnt_d = '0;
                        bit_idx_d = '0;
                        acc_d     = '0;
                        pwm_d     = 1'b0;
                        ur_cnt_d  = '0;
                        first_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state_q    <= ST_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            acc_q      <= '0;
            pwm_q      <= 1'b0;
            ur_cnt_q   <= '0;
            underrun_q <= 1'b0;
            first_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            acc_q      <= acc_d;
            pwm_q      <= pwm_d;
            ur_cnt_q   <= ur_cnt_d;
            underrun_q <= underrun_d;
            first_q    <= first_d;
        end
    end

    // The held sample is always reloaded at the first boundary, so it needs no reset.
    always_ff @(posedge CLK_IN) begin
        cur_u_q <= cur_u_d;
    end

    assign AUD_PWM   = pwm_q;
    assign AUD_SD    = (state_q == ST_RUN);
    assign ACTIVE    = (state_q == ST_RUN);
    assign UNDERRUN  = underrun_q;
    assign PCM_READY = fifo_ready;

endmodule

// File: doc/pdm_output.md
# pdm_output

PCM-to-PDM transmitter: the playback counterpart of the PDM microphone input path. Accepts signed 16-bit PCM samples over a valid/ready handshake, buffers them in a small FIFO, and converts each sample into `OSR` bits of pulse-density-modulated output with a first-order sigma-delta modulator. The output drives the board audio amplifier pin (`AUD_PWM`, low-pass filtered off-chip) plus its shutdown pin (`AUD_SD`). It sits in the PL between a PCM source (test tone generator or DMA) and the audio pins.

## Interface
- `CLK_FREQ`, 125, `CLK_IN` frequency in MHz.
- `SAMPLE_RATE`, 2400000, PDM bit rate in Hz; `CLK_COUNT = (CLK_FREQ*1000000)/SAMPLE_RATE` (integer, ≥2).
- `OSR`, 64, PDM bits per PCM sample (power of two, ≥2).
- `FIFO_DEPTH`, 4, PCM FIFO entries (power of two, ≥2).
- `UNDERRUN_LIMIT`, 4, consecutive underrun samples before returning to IDLE.
- `CLK_IN`  in  1  system clock; one clock domain. Reset is synchronous and active-high.
- `RST_IN`  in  1  synchronous, active-high reset.
- `PCM_DATA`  in  16  signed two's-complement sample.
- `PCM_VALID`  in  1  sample present.
- `PCM_READY`  out  1  FIFO can accept; transfer when `PCM_VALID & PCM_READY`.
- `AUD_PWM`  out  1  PDM bitstream.
- `AUD_SD`  out  1  amplifier enable (1 = on).
- `UNDERRUN`  out  1  one-cycle pulse per sample boundary with FIFO empty in RUN.
- `ACTIVE`  out  1  high in RUN.

## Operation
- Bit strobe: `clk_counter` runs 0..`CLK_COUNT`-1 and wraps; `bit_en` is high for one cycle when it equals `CLK_COUNT`-1. `bit_idx` counts 0..`OSR`-1 on `bit_en`; a sample boundary is the `bit_en` with `bit_idx == OSR-1` (or the first `bit_en` in RUN).
- Offset conversion: `u = PCM ^ 16'h8000` (unsigned; -32768→0, 0→0x8000, 32767→0xFFFF).
- Modulator: 16-bit `acc`; on each `bit_en` in RUN, `{carry, acc} <= acc + u` (17-bit sum); `AUD_PWM <= carry`. Exact density `u/65536`. `acc` is cleared on reset and on entry to IDLE; it is never cleared at sample boundaries.
- FSM:
  - IDLE: `AUD_SD=0`, `AUD_PWM=0`, `ACTIVE=0`, `clk_counter`/`bit_idx` held at 0. FIFO accepts. Go to RUN when FIFO count ≥ `FIFO_DEPTH/2`.
  - RUN: `AUD_SD=1`, `ACTIVE=1`. At each sample boundary pop the FIFO into the current-sample register. If the FIFO is empty, load midscale (`u=0x8000`), pulse `UNDERRUN`, and increment `underrun_cnt`. A successful pop clears `underrun_cnt`. When `underrun_cnt` reaches `UNDERRUN_LIMIT`, go to IDLE at that boundary.
- FIFO: `PCM_READY = !full`, registered. A push and a pop in the same cycle leave the count unchanged. A push is never dropped while `PCM_READY=1`.
- Reset (any time, including mid-sample): FIFO emptied, FSM → IDLE, all counters and `acc` = 0.

## Timing
- Reset values: `AUD_PWM=0`, `AUD_SD=0`, `PCM_READY=0`, `UNDERRUN=0`, `ACTIVE=0`. `PCM_READY=1` on the first cycle after `RST_IN` deasserts.
- `AUD_PWM` is registered and changes one `CLK_IN` cycle after `bit_en`. Each bit lasts exactly `CLK_COUNT` cycles.
- Latency from the `FIFO_DEPTH/2`-th accepted sample to the first PDM bit: ≤ `CLK_COUNT`+2 cycles.
- `UNDERRUN` is aligned with the `AUD_PWM` update of the boundary's first bit.
- `PCM_READY` falls the cycle after the push that fills the FIFO and rises the cycle after the pop that frees an entry.

## Structure
- Shared package `pdm_pkg`: FSM state encodings (IDLE, RUN), `MIDSCALE = 16'h8000`, `CLK_COUNT` computation, and PCM width constant 16. Also used by `pdm_input`.
- One sub-module: `pdm_fifo`, a synchronous FIFO (`FIFO_DEPTH` × 16, push/pop, full/empty/count).
- Top module contains the strobe counters, FSM, and modulator.

## Test plan
Defaults apply (`CLK_COUNT=52`, `OSR=64`).
- Reset: hold `RST_IN` 3 cycles → all outputs at their reset values; `PCM_READY=1` on the cycle after release.
- Push 0x0000 ×2 → RUN; `AUD_PWM` alternates 0,1,0,1…; 32 ones per 64 bits; each bit is 52 cycles wide.
- Push 0x7FFF ×2 → first sample gives bit0=0 then 63 ones. Push 0x8000 → all 64 bits 0.
- Hold `PCM_VALID=1` continuously with incrementing data → `PCM_READY` low whenever 4 entries are held. No sample is lost or duplicated; the popped order matches the pushed order.
- Push 2 samples, then stop → `UNDERRUN` pulses at boundaries 3–6 with an alternating midscale pattern; after the 4th pulse, `AUD_SD=0`, `AUD_PWM=0`, `ACTIVE=0`. Pushing 2 more restarts RUN with `acc=0`.
- Assert `RST_IN` at bit 30 of a sample with 3 queued → outputs go to reset values next cycle; FIFO is empty; no stale sample appears after re-priming.
